systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//  Upstream stage of matrix_multiply. Accepts whole NxN operand matrices A and B over a
//  valid/ready handshake, stores them, and replays them as the diagonally skewed row/column
//  streams the systolic array consumes on in_a/in_b. Pulses feed_clear before each job and
//  feed_done after the drain, so the array is cleared and each job is framed without manual timing.
// PARAMETERS
//  MATRIX_SIZE   3     N, array dimension
//  ELEM_W        8     width of one stored matrix element (unsigned)
//  DATA_SIZE     1024  width of each feed lane (matches matrix_multiply DATA_SIZE); ELEM_W <= DATA_SIZE
//  FLUSH_CYCLES  3     zero cycles driven after the last data cycle (array drain); >= 1
// PORTS
//  clk         in   1                  rising-edge clock
//  reset       in   1                  asynchronous, active-high
//  s_valid     in   1                  job offered
//  s_ready     out  1                  feeder can accept a job
//  s_mat_a     in   N*N*ELEM_W         A, row-major: A[r][c] at bits [(r*N+c)*ELEM_W +: ELEM_W]
//  s_mat_b     in   N*N*ELEM_W         B, same packing
//  feed_a      out  [N-1:0][DATA_SIZE] to matrix_multiply in_a (lane i = row i of A)
//  feed_b      out  [N-1:0][DATA_SIZE] to matrix_multiply in_b (lane j = column j of B)
//  feed_clear  out  1                  one-cycle accumulator clear for the array
//  feed_active out  1                  high on every STREAM cycle
//  feed_done   out  1                  one-cycle pulse on final FLUSH cycle
// BEHAVIOUR
//  - Reset (async assert): state IDLE, counter 0, stored matrices 0; s_ready=1, all feed_* = 0.
//  - All outputs decoded from registers only; no comb path from s_* inputs to any output.
//  - FSM: IDLE -> CLEAR -> STREAM -> FLUSH -> IDLE.
//    IDLE:   s_ready=1; on s_valid&&s_ready at edge: capture s_mat_a/s_mat_b, go CLEAR.
//    CLEAR:  exactly 1 cycle; feed_clear=1, feeds 0; go STREAM with t=0.
//    STREAM: 2N-1 cycles, t=0..2N-2; feed_active=1;
//            feed_a[i] = (0<=t-i<N) ? zext(A[i][t-i]) : 0;  feed_b[j] = (0<=t-j<N) ? zext(B[t-j][j]) : 0.
//            at t=2N-2 go FLUSH, counter reset.
//    FLUSH:  FLUSH_CYCLES cycles, feeds 0; feed_done=1 on last one; then IDLE.
//  - s_ready=0 in CLEAR/STREAM/FLUSH; s_valid there is ignored, no capture. s_mat_* need only be
//    stable in the accept cycle. Job latency: accept edge -> first data = 2 cycles; accept ->
//    feed_done = 1+(2N-1)+FLUSH_CYCLES cycles; next accept earliest the cycle after feed_done.
//  - Width: elements zero-extended ELEM_W -> DATA_SIZE; no arithmetic on data.
//  - Counter width $clog2(max(2N-1,FLUSH_CYCLES)+1); never wraps (reset at each state change).
//  - Reset mid-job: immediate return to IDLE, feeds/pulses 0 same instant, stored data discarded;
//    no feed_done for the aborted job.
// STRUCTURE
//  - systolic_pkg: state enum (ST_IDLE, ST_CLEAR, ST_STREAM, ST_FLUSH), function
//    skew_idx(t,lane) returning {in_range, elem_index}, localparam STREAM_LEN = 2*N-1.
//  - Sub-module systolic_skew_lane: given t, lane index, and one stored row/column, returns the
//    zero-extended element or 0; instantiated N times for A and N times for B.
// TESTING (N=3, A=[1 2 3;4 5 6;7 8 9], B=[2 1 3;4 5 7;6 9 8])
//  1 Reset held then released -> s_ready=1, feed_a/feed_b all 0, feed_clear/active/done 0.
//  2 Single job -> CLEAR pulse, then feed_a per cycle {1,0,0},{2,4,0},{3,5,7},{0,6,8},{0,0,9};
//    feed_b {2,0,0},{4,1,0},{6,5,3},{0,9,7},{0,0,8}; 3 zero cycles; feed_done on 3rd;
//    chained into matrix_multiply -> out_matrix = {28,38,41,64,83,95,100,128,149}.
//  3 s_valid held high with different matrices during job -> s_ready=0, stream unchanged; 2nd job
//    accepted the cycle after feed_done, its CLEAR next cycle.
//  4 reset asserted at STREAM t=2 -> feeds 0 immediately, no feed_done; next job streams correctly.
//  5 A,B all elements 8'hFF -> every in-range lane value = 255 exactly, upper bits 0.
//  6 s_valid never asserted for 20 cycles -> outputs stay 0, s_ready stays 1, no pulses.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic skew feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic        in_range;
        logic [31:0] elem_index;
    } skew_t;

    // Lane k carries element (t - k) of its row/column at stream step t;
    // outside 0..n-1 the lane is idle and must drive zero.
    function automatic skew_t skew_idx(input int t, input int lane, input int n);
        skew_t r;
        int    d;
        d = t - lane;
        r.in_range   = (d >= 0) && (d < n);
        r.elem_index = r.in_range ? 32'(d) : '0;
        return r;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed feed lane: picks element (t - LANE) of a stored row/column and
// zero-extends it, or drives zero when that element does not exist yet/anymore.
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int N         = 3,
    parameter int ELEM_W    = 8,
    parameter int DATA_SIZE = 1024,
    parameter int CNT_W     = 3,
    parameter int LANE      = 0
) (
    input  logic [CNT_W-1:0]           t,
    input  logic                       enable,
    input  logic [N-1:0][ELEM_W-1:0]   vec,
    output logic [DATA_SIZE-1:0]       value
);

    skew_t sk;

    // Select-and-extend; the compare loop avoids a wide variable index.
    always_comb begin
        sk    = skew_idx(int'(t), LANE, N);
        value = '0;
        for (int c = 0; c < N; c++) begin
            if (enable && sk.in_range && (sk.elem_index == 32'(c))) begin
                value[ELEM_W-1:0] = vec[c];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Captures an NxN A/B job, then replays it as diagonally skewed row (A) and
// column (B) streams for a systolic array, framed by feed_clear / feed_done.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | s_ready=1, waiting for s_valid; feeds zero
// ST_CLEAR  | one cycle feed_clear pulse, feeds zero
// ST_STREAM | 2N-1 cycles of skewed data, feed_active=1, cnt = t
// ST_FLUSH  | FLUSH_CYCLES zero cycles for array drain, feed_done on last
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE  = 3,
    parameter int ELEM_W       = 8,
    parameter int DATA_SIZE    = 1024,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*ELEM_W-1:0]     s_mat_a,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*ELEM_W-1:0]     s_mat_b,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]         feed_a,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]         feed_b,
    output logic                                          feed_clear,
    output logic                                          feed_active,
    output logic                                          feed_done
);

    localparam int N          = MATRIX_SIZE;
    localparam int STREAM_LEN = 2 * N - 1;
    localparam int CNT_MAX    = (STREAM_LEN > FLUSH_CYCLES) ? STREAM_LEN : FLUSH_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    state_t                          state, next_state;
    logic [CNT_W-1:0]                cnt, cnt_next;
    logic                            capture;
    logic [N-1:0][N-1:0][ELEM_W-1:0] mat_a, mat_b, col_b;

    // State and step counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and all control outputs decoded from the state register.
    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        capture     = 1'b0;
        s_ready     = 1'b0;
        feed_clear  = 1'b0;
        feed_active = 1'b0;
        feed_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                s_ready  = 1'b1;
                cnt_next = '0;
                if (s_valid) begin
                    capture    = 1'b1;
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                feed_clear = 1'b1;
                cnt_next   = '0;
                next_state = ST_STREAM;
            end
            ST_STREAM: begin
                feed_active = 1'b1;
                if (cnt == CNT_W'(STREAM_LEN - 1)) begin
                    cnt_next   = '0;
                    next_state = ST_FLUSH;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                    feed_done  = 1'b1;
                    cnt_next   = '0;
                    next_state = ST_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Operand storage; the flat row-major input maps directly onto [row][col].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mat_a <= '0;
            mat_b <= '0;
        end else if (capture) begin
            mat_a <= s_mat_a;
            mat_b <= s_mat_b;
        end
    end

    // Transpose B so each B lane sees one column as a contiguous vector.
    always_comb begin
        col_b = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                col_b[c][r] = mat_b[r][c];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_skew_lane #(
            .N         (N),
            .ELEM_W    (ELEM_W),
            .DATA_SIZE (DATA_SIZE),
            .CNT_W     (CNT_W),
            .LANE      (i)
        ) u_lane_a (
            .t      (cnt),
            .enable (feed_active),
            .vec    (mat_a[i]),
            .value  (feed_a[i])
        );

        systolic_skew_lane #(
            .N         (N),
            .ELEM_W    (ELEM_W),
            .DATA_SIZE (DATA_SIZE),
            .CNT_W     (CNT_W),
            .LANE      (i)
        ) u_lane_b (
            .t      (cnt),
            .enable (feed_active),
            .vec    (col_b[i]),
            .value  (feed_b[i])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: per-cycle comparison against a
// job-level frame queue model, spec vector tables, and a product check.
module tb_systolic_skew_feeder;

    localparam int N  = 3;
    localparam int E  = 8;
    localparam int D  = 16;
    localparam int F  = 3;
    localparam int MW = N * N * E;

    typedef int mat_t [N*N];
    typedef logic [N-1:0][D-1:0] lanes_t;

    typedef struct packed {
        logic   ready;
        logic   clear;
        logic   active;
        logic   done;
        lanes_t fa;
        lanes_t fb;
    } frame_t;

    typedef struct {
        int a [N];
        int b [N];
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [MW-1:0] s_mat_a, s_mat_b;
    lanes_t        feed_a, feed_b;
    logic          feed_clear, feed_active, feed_done;

    frame_t q[$];
    lanes_t rec_fa[$], rec_fb[$];
    logic   rec_clear[$], rec_done[$];
    int     passed = 0;
    int     total  = 0;

    systolic_skew_feeder #(
        .MATRIX_SIZE  (N),
        .ELEM_W       (E),
        .DATA_SIZE    (D),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_mat_a     (s_mat_a),
        .s_mat_b     (s_mat_b),
        .feed_a      (feed_a),
        .feed_b      (feed_b),
        .feed_clear  (feed_clear),
        .feed_active (feed_active),
        .feed_done   (feed_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

    function automatic logic [MW-1:0] pack(input mat_t m);
        logic [MW-1:0] v;
        v = '0;
        for (int k = 0; k < N * N; k++) v[k*E +: E] = 8'(m[k]);
        return v;
    endfunction

    function automatic frame_t idle_frame();
        frame_t f;
        f = '0;
        f.ready = 1'b1;
        return f;
    endfunction

    // Whole-job expectation: 1 clear frame, 2N-1 skewed frames, F flush frames.
    task automatic push_job(input logic [MW-1:0] ma, input logic [MW-1:0] mb);
        frame_t f;
        int     k;
        f = '0;
        f.clear = 1'b1;
        q.push_back(f);
        for (int t = 0; t < 2 * N - 1; t++) begin
            f = '0;
            f.active = 1'b1;
            for (int i = 0; i < N; i++) begin
                k = t - i;
                if (k >= 0 && k < N) begin
                    f.fa[i] = D'(ma[(i*N+k)*E +: E]);
                    f.fb[i] = D'(mb[(k*N+i)*E +: E]);
                end
            end
            q.push_back(f);
        end
        for (int c = 0; c < F; c++) begin
            f = '0;
            f.done = (c == F - 1);
            q.push_back(f);
        end
    endtask

    task automatic check_frame(input string name);
        frame_t exp_f, act_f;
        exp_f = (q.size() != 0) ? q[0] : idle_frame();
        act_f.ready  = s_ready;
        act_f.clear  = feed_clear;
        act_f.active = feed_active;
        act_f.done   = feed_done;
        act_f.fa     = feed_a;
        act_f.fb     = feed_b;
        total++;
        if (act_f === exp_f) passed++;
        else $display("FAIL %s @%0t: got %h want %h", name, $time, act_f, exp_f);
    endtask

    task automatic check_val(input string name, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    endtask

    // Model reaction to a rising edge: a job is accepted only when nothing is in flight.
    task automatic model_edge();
        logic acc;
        acc = (q.size() == 0) && s_valid && !reset;
        if (q.size() != 0) void'(q.pop_front());
        if (acc) push_job(s_mat_a, s_mat_b);
    endtask

    // Called at a negedge with inputs already set; ends at the next negedge.
    task automatic cycle(input string name);
        check_frame(name);
        rec_fa.push_back(feed_a);
        rec_fb.push_back(feed_b);
        rec_clear.push_back(feed_clear);
        rec_done.push_back(feed_done);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_rec();
        rec_fa.delete();
        rec_fb.delete();
        rec_clear.delete();
        rec_done.delete();
    endtask

    // Asynchronous reset between edges; outputs must drop at once.
    task automatic reset_pulse(input string name);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check_frame({name, "_async"});
        @(posedge clk);
        @(negedge clk);
        check_frame({name, "_held"});
        reset = 1'b0;
    endtask

    mat_t   ma_t, mb_t, mc_t, md_t, mff_t;
    vec_t   tbl [5];
    int     exp_c [N*N];
    int     sum, ta, tb;

    initial begin
        ma_t  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mb_t  = '{2, 1, 3, 4, 5, 7, 6, 9, 8};
        mc_t  = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
        md_t  = '{21, 22, 23, 24, 25, 26, 27, 28, 29};
        mff_t = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        tbl[0].a = '{1, 0, 0}; tbl[0].b = '{2, 0, 0};
        tbl[1].a = '{2, 4, 0}; tbl[1].b = '{4, 1, 0};
        tbl[2].a = '{3, 5, 7}; tbl[2].b = '{6, 5, 3};
        tbl[3].a = '{0, 6, 8}; tbl[3].b = '{0, 9, 7};
        tbl[4].a = '{0, 0, 9}; tbl[4].b = '{0, 0, 8};
        exp_c = '{28, 38, 41, 64, 83, 95, 100, 128, 149};

        // 1: reset held then released
        reset   = 1'b1;
        s_valid = 1'b0;
        s_mat_a = '0;
        s_mat_b = '0;
        @(negedge clk);
        @(negedge clk);
        check_frame("reset_held");
        reset = 1'b0;
        #1;
        check_frame("reset_released");
        @(negedge clk);

        // 6: idle, no s_valid for 20 cycles
        for (int c = 0; c < 20; c++) cycle("idle_20");

        // 2: single job against the spec stream table and the array product
        s_mat_a = pack(ma_t);
        s_mat_b = pack(mb_t);
        s_valid = 1'b1;
        clear_rec();
        cycle("job1_accept");
        s_valid = 1'b0;
        s_mat_a = '0;
        s_mat_b = '0;
        for (int c = 0; c < 10; c++) cycle("job1_run");
        check_val("job1_clear_pulse", int'(rec_clear[1]), 1);
        check_val("job1_done_early", int'(rec_done[8]), 0);
        check_val("job1_done_pulse", int'(rec_done[9]), 1);
        check_val("job1_done_after", int'(rec_done[10]), 0);
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++) begin
                check_val($sformatf("tbl_a_t%0d_l%0d", t, i), int'(rec_fa[2+t][i]), tbl[t].a[i]);
                check_val($sformatf("tbl_b_t%0d_l%0d", t, i), int'(rec_fb[2+t][i]), tbl[t].b[i]);
            end
        end
        // PE(i,j) sees lane a_i delayed by j and lane b_j delayed by i.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int tau = 0; tau < 4 * N; tau++) begin
                    ta = tau - j;
                    tb = tau - i;
                    if (ta >= 0 && ta < 2 * N - 1 && tb >= 0 && tb < 2 * N - 1)
                        sum += int'(rec_fa[2+ta][i]) * int'(rec_fb[2+tb][j]);
                end
                check_val($sformatf("product_c%0d%0d", i, j), sum, exp_c[i*N+j]);
            end
        end

        // 3: s_valid held high with other matrices during the job
        s_mat_a = pack(ma_t);
        s_mat_b = pack(mb_t);
        s_valid = 1'b1;
        clear_rec();
        cycle("job2_accept");
        s_mat_a = pack(mc_t);
        s_mat_b = pack(md_t);
        for (int c = 0; c < 9; c++) cycle("job2_busy");
        cycle("job3_accept");
        s_valid = 1'b0;
        cycle("job3_clear");
        check_val("job2_done_idx9", int'(rec_done[9]), 1);
        check_val("job3_clear_idx11", int'(rec_clear[11]), 1);
        check_val("job2_stream_t2_a2", int'(rec_fa[4][2]), 7);
        for (int c = 0; c < 10; c++) cycle("job3_run");

        // 4: reset at STREAM t=2, then a fresh job
        s_mat_a = pack(ma_t);
        s_mat_b = pack(mb_t);
        s_valid = 1'b1;
        cycle("job4_accept");
        s_valid = 1'b0;
        for (int c = 0; c < 3; c++) cycle("job4_pre");
        check_frame("job4_t2_before_reset");
        check_val("job4_t2_a0", int'(feed_a[0]), 3);
        reset_pulse("job4_reset");
        clear_rec();
        for (int c = 0; c < 12; c++) cycle("job4_after_reset");
        for (int c = 0; c < 12; c++) check_val("no_done_after_abort", int'(rec_done[c]), 0);
        s_mat_a = pack(mb_t);
        s_mat_b = pack(ma_t);
        s_valid = 1'b1;
        cycle("job5_accept");
        s_valid = 1'b0;
        for (int c = 0; c < 10; c++) cycle("job5_run");

        // 5: all-0xFF operands, exact 255 in range and 0 elsewhere
        s_mat_a = pack(mff_t);
        s_mat_b = pack(mff_t);
        s_valid = 1'b1;
        clear_rec();
        cycle("ff_accept");
        s_valid = 1'b0;
        for (int c = 0; c < 10; c++) cycle("ff_run");
        for (int t = 0; t < 2 * N - 1; t++) begin
            for (int i = 0; i < N; i++) begin
                check_val($sformatf("ff_a_t%0d_l%0d", t, i), int'(rec_fa[2+t][i]),
                          (t - i >= 0 && t - i < N) ? 255 : 0);
                check_val($sformatf("ff_b_t%0d_l%0d", t, i), int'(rec_fb[2+t][i]),
                          (t - i >= 0 && t - i < N) ? 255 : 0);
            end
        end

        // Random traffic with occasional mid-job resets
        for (int c = 0; c < 400; c++) begin
            s_valid = ($urandom_range(0, 2) == 0);
            s_mat_a = MW'({$urandom(), $urandom(), $urandom()});
            s_mat_b = MW'({$urandom(), $urandom(), $urandom()});
            if ($urandom_range(0, 79) == 0) reset_pulse("rand_reset");
            else cycle("rand");
        end
        s_valid = 1'b0;
        for (int c = 0; c < 12; c++) cycle("final_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
